slicem_ram_writer: RTL
======================

Name: slicem_ram_writer

Overview:
- Write-side initiator for the memory slice's LUT-RAM port.
- Accepts word-wide write requests over a valid/ready handshake. Serializes each word into the slice's single-bit write interface: data_in, write_en, write_lut_select, higher_order_addr, and a per-LUT bit address.
- Sits between a host/config bus and the slice. The integrator replicates lut_addr into every luts_in entry.

Parameters:
- S_XX_BASE, 4, LUT input count; bit-address width within one LUT half.
- NUM_LUTS, 4, LUTs in the target slice (power of 2).
- MUX_LVLS, $clog2(NUM_LUTS), LUT-select width.
- ADDR_W, MUX_LVLS+1+S_XX_BASE, flat bit-address width (128 bits at defaults).
- DATA_W, 8, max bits per request.
- LEN_W, $clog2(DATA_W), width of the length field.

Ports:
- clk  in  1  single clock; also clocks the slice RAM writes.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_W  flat bit address of the first bit.
- req_data  in  DATA_W  payload, written LSB first.
- req_len  in  LEN_W  number of bits minus 1.
- lut_addr  out  S_XX_BASE  flat address bits [S_XX_BASE-1:0].
- write_lut_select  out  1  flat address bit [S_XX_BASE].
- higher_order_addr  out  MUX_LVLS  flat address bits [ADDR_W-1:S_XX_BASE+1].
- data_in  out  1  bit being written.
- write_en  out  1  write strobe, sampled by the slice at posedge clk.
- rd_bit  in  1  combinational readback of the addressed LUT bit; used only with the optional feature.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse after the last bit of a request.
- verify_err  out  1  sticky mismatch flag.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state IDLE. All of the following are 0: write_en, data_in, lut_addr, write_lut_select, higher_order_addr, busy, done, verify_err. req_ready is 1 from the first cycle after reset.
- States: IDLE, WRITE, plus VERIFY when the optional feature is compiled in.
- Accept: a request is accepted in the cycle where req_valid and req_ready are both high (IDLE). That cycle:
  - latch data into a shift register;
  - latch the address into a counter;
  - latch len into a down-counter;
  - clear verify_err;
  - go to WRITE.
- WRITE (one cycle per bit), with bit k of a request accepted in cycle T:
  - In cycle T+1+k, drive write_en=1, data_in=req_data[k], and the address fields from addr+k.
  - Then shift data, increment the address and decrement the count.
  - When count==0, go to IDLE (no feature) or VERIFY (feature).
  - Outputs are registered, so write_en, data and address change together.
- done timing: asserted in cycle T+2+len, the first IDLE cycle, together with req_ready=1.
  - A new request may be accepted in that same cycle.
  - Back-to-back requests leave one write_en-low cycle between them.
- Address arithmetic: increment modulo 2^ADDR_W.
  - Crossing lut_addr all-ones toggles write_lut_select.
  - Crossing both LUT halves increments higher_order_addr.
  - 0x7F wraps to 0x00 at defaults.
- Outside WRITE: write_en=0. Address and data outputs hold their last values.
- req_len == DATA_W-1 is the maximum; req_len == 0 writes exactly one bit.
- req_valid while busy is ignored and not buffered. The requester holds it until ready.
- Reset mid-operation: write_en is low in the cycle after rst is sampled and the FSM returns to IDLE. Bits already strobed remain in the RAM; no done pulse is issued.
- Without the optional feature, rd_bit is ignored and verify_err stays 0.

Optional Feature:
- Macro: SLICEM_WR_VERIFY_EN.
- Defined:
  - each WRITE cycle for a bit is followed by one VERIFY cycle;
  - in the VERIFY cycle write_en=0, the address is held, and rd_bit is compared to the bit just written;
  - a mismatch sets verify_err, which stays set until the next accept;
  - after the VERIFY cycle the FSM goes to WRITE for the next bit, or to IDLE after the last;
  - latency becomes 2*(len+1) cycles of busy;
  - done is asserted at T+2+2*(len+1)-1, i.e. the first IDLE cycle.
- Undefined: no VERIFY state; timing exactly as in Behaviour.

Decomposition:
- slicem_pkg holds:
  - shared constants S_XX_BASE_DEF=4 and NUM_LUTS_DEF=4;
  - address-field offset constants;
  - the state enum typedef wr_state_t {IDLE, WRITE, VERIFY}.
- The address split and serializer are simple enough to live in one module; no sub-module.

Test Plan:
- Single bit: req_addr=0x05, data=0x01, len=0 → one write_en cycle at T+1 with lut_addr=5, sel=0, hoa=0, data_in=1; done at T+2.
- Half crossing: addr=0x0E, data=0xA5, len=7 → eight strobes at addresses 0x0E..0x15; data_in sequence 1,0,1,0,0,1,0,1; write_lut_select goes 0→1 at the third strobe; done at T+9.
- Wrap: addr=0x7E, len=3, data=0x0F → addresses 0x7E,0x7F,0x00,0x01; hoa goes 3→0.
- Back-to-back plus busy rejection: req_valid held high with a second request → second accepted in the done cycle; req_valid pulsed mid-WRITE is not accepted.
- Reset mid-write: rst asserted at the 3rd strobe of a len=7 request → write_en=0 the next cycle, no done, req_ready=1, all outputs zero.
- SLICEM_WR_VERIFY_EN: rd_bit forced 0 while writing data=0x02, len=1 → strobes at T+1 and T+3; verify_err set after the second bit's VERIFY cycle; the next accept clears it.

Source files
------------

// File: rtl/slicem_ram_writer_pkg.sv
// Shared constants, address-field offsets and FSM state type for the
// slice LUT-RAM write initiator.
package slicem_pkg;

    localparam int S_XX_BASE_DEF = 4;
    localparam int NUM_LUTS_DEF  = 4;

    // Flat bit address layout: {higher_order_addr, write_lut_select, lut_addr}
    localparam int LUT_ADDR_OFS = 0;

    function automatic int sel_ofs(input int s_xx_base);
        return s_xx_base;
    endfunction

    function automatic int hoa_ofs(input int s_xx_base);
        return s_xx_base + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2
    } wr_state_t;

endpackage

// File: rtl/slicem_ram_writer_if.sv
// Word-wide write-request handshake between the host/config bus and the
// slice LUT-RAM writer.
interface slicem_ram_writer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 3
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [LEN_W-1:0]  req_len;

    modport master (
        output req_valid, req_addr, req_data, req_len,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_len,
        output req_ready
    );

endinterface

// File: rtl/slicem_ram_writer.sv
// Serializes word write requests into the slice's single-bit LUT-RAM port.
// Define SLICEM_WR_VERIFY_EN to add a read-back VERIFY cycle after every bit.
module slicem_ram_writer
    import slicem_pkg::*;
#(
    parameter int S_XX_BASE = S_XX_BASE_DEF,
    parameter int NUM_LUTS  = NUM_LUTS_DEF,
    parameter int MUX_LVLS  = $clog2(NUM_LUTS),
    parameter int ADDR_W    = MUX_LVLS + 1 + S_XX_BASE,
    parameter int DATA_W    = 8,
    parameter int LEN_W     = $clog2(DATA_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    slicem_ram_writer_if.slave   req,
    output logic [S_XX_BASE-1:0] lut_addr,
    output logic                 write_lut_select,
    output logic [MUX_LVLS-1:0]  higher_order_addr,
    output logic                 data_in,
    output logic                 write_en,
    input  logic                 rd_bit,
    output logic                 busy,
    output logic                 done,
    output logic                 verify_err
);

    localparam int SEL_BIT = sel_ofs(S_XX_BASE);
    localparam int HOA_LSB = hoa_ofs(S_XX_BASE);

    wr_state_t         state_q, state_d;
    logic              accept, advance, finish, check_bit;

    logic [DATA_W-1:0] shift_q;
    logic [ADDR_W-1:0] next_addr_q;
    logic [LEN_W-1:0]  cnt_q;

    logic [ADDR_W-1:0] addr_out_q;
    logic              we_q, din_q, done_q, verr_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        check_bit = 1'b0;
        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    accept  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
`ifdef SLICEM_WR_VERIFY_EN
                state_d = VERIFY;
`else
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else begin
                    advance = 1'b1;
                end
`endif
            end
            VERIFY: begin
`ifdef SLICEM_WR_VERIFY_EN
                check_bit = 1'b1;
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else begin
                    advance = 1'b1;
                    state_d = WRITE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the working registers are loaded on every accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_q     <= req.req_data >> 1;
            next_addr_q <= req.req_addr + 1'b1;
            cnt_q       <= req.req_len;
        end else if (advance) begin
            shift_q     <= shift_q >> 1;
            next_addr_q <= next_addr_q + 1'b1;
            cnt_q       <= cnt_q - 1'b1;
        end
    end

    // Strobe, data and address are registered together so the slice sees them aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            din_q      <= 1'b0;
            addr_out_q <= '0;
            done_q     <= 1'b0;
            verr_q     <= 1'b0;
        end else begin
            we_q   <= accept | advance;
            done_q <= finish;
            if (accept) begin
                din_q      <= req.req_data[0];
                addr_out_q <= req.req_addr;
                verr_q     <= 1'b0;
            end else if (advance) begin
                din_q      <= shift_q[0];
                addr_out_q <= next_addr_q;
            end
            if (check_bit && (rd_bit != din_q)) verr_q <= 1'b1;
        end
    end

    assign req.req_ready      = (state_q == IDLE);
    assign busy               = (state_q != IDLE);
    assign write_en           = we_q;
    assign data_in            = din_q;
    assign done               = done_q;
    assign verify_err         = verr_q;
    assign lut_addr           = addr_out_q[S_XX_BASE-1:LUT_ADDR_OFS];
    assign write_lut_select   = addr_out_q[SEL_BIT];
    assign higher_order_addr  = addr_out_q[ADDR_W-1:HOA_LSB];

endmodule
